// File: rtl/pcd_pkg.sv
// pcd_pkg: shared types and constants for the PCD-side load-modulation
// receiver (pcd_lm_decoder and its half-bit detector).
//   state_t        - receiver FSM states
//   half_t         - classification of one Manchester half-bit
//   BITS_PER_GROUP - 8 data bits plus one odd-parity bit
package pcd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SOC1,
        SOC2,
        DATA,
        RECOVER
    } state_t;

    typedef enum logic {
        HALF_U,
        HALF_M
    } half_t;

    localparam int BITS_PER_GROUP = 9;

    // Odd parity: a correct byte+parity group has an odd number of ones.
    function automatic logic odd_parity_error(input logic [7:0] d, input logic p);
        return ~(^{d, p});
    endfunction

endpackage

// File: rtl/subcarrier_half_detector.sv
// subcarrier_half_detector: classifies consecutive Manchester half-bits of
// the load-modulation input as modulated (HALF_M) or unmodulated (HALF_U).
//   clk, rst   - carrier clock, async active-high reset
//   start      - this cycle's lm_in sample is tick 0 of a new half-bit
//   run        - keep counting back-to-back half-bits; low clears counters
//   lm_in      - synchronous load-modulation sample
//   half_done  - one-cycle pulse, registered on the edge that takes the
//                last sample of a half-bit
//   half_mod   - classification of that half-bit, valid with half_done
module subcarrier_half_detector
    import pcd_pkg::*;
#(
    parameter int HALF_BIT_TICKS = 64,
    parameter int MOD_THRESHOLD  = 16
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  start,
    input  logic  run,
    input  logic  lm_in,
    output logic  half_done,
    output half_t half_mod
);

    localparam int CW = $clog2(HALF_BIT_TICKS + 1);
    localparam logic [CW-1:0] LAST_TICK = CW'(HALF_BIT_TICKS - 1);
    localparam logic [CW:0]   THRESH    = (CW + 1)'(MOD_THRESHOLD);

    logic [CW-1:0] tick_cnt;
    logic [CW-1:0] high_cnt;
    logic [CW:0]   high_total;

    // Include the current (last) sample in the decision.
    assign high_total = {1'b0, high_cnt} + {{CW{1'b0}}, lm_in};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt  <= '0;
            high_cnt  <= '0;
            half_done <= 1'b0;
            half_mod  <= HALF_U;
        end else begin
            half_done <= 1'b0;
            if (start) begin
                tick_cnt <= CW'(1);
                high_cnt <= {{(CW-1){1'b0}}, lm_in};
            end else if (!run) begin
                tick_cnt <= '0;
                high_cnt <= '0;
            end else if (tick_cnt == LAST_TICK) begin
                half_done <= 1'b1;
                half_mod  <= (high_total >= THRESH) ? HALF_M : HALF_U;
                tick_cnt  <= '0;
                high_cnt  <= '0;
            end else begin
                tick_cnt <= tick_cnt + CW'(1);
                if (high_cnt != '1) begin
                    high_cnt <= high_cnt + {{(CW-1){1'b0}}, lm_in};
                end
            end
        end
    end

endmodule

// File: rtl/pcd_lm_decoder.sv
// pcd_lm_decoder: reader-side receiver for ISO/IEC 14443-2A PICC->PCD load
// modulation (Manchester on an fc/16 subcarrier). Recovers SOC, data bits,
// odd parity and EOC and emits bytes with parity/coding status.
//   clk, rst      - 13.56 MHz clock, async active-high reset
//   lm_in         - synchronous load-modulation sample
//   enable        - low forces IDLE and drops any frame in progress
//   soc           - pulse: start of communication confirmed
//   data_valid    - pulse: data/data_bits/parity_error valid
//   data          - received bits, bit 0 first on air
//   data_bits     - valid bits in data, 0 means 8
//   parity_error  - odd parity check result for full bytes
//   eoc           - pulse: end of communication
//   coding_error  - pulse: Manchester violation or missing parity
//   busy          - FSM not in IDLE
//   dbg_state     - current FSM state
//
// Output protocol: soc, data_valid, eoc and coding_error are single-cycle
// valid strobes with no ready/backpressure; the consumer must take every
// strobe in the cycle it is high. data, data_bits and parity_error hold
// their last value until the next data_valid.
module pcd_lm_decoder
    import pcd_pkg::*;
#(
    parameter int HALF_BIT_TICKS = 64,
    parameter int MOD_THRESHOLD  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lm_in,
    input  logic       enable,
    output logic       soc,
    output logic       data_valid,
    output logic [7:0] data,
    output logic [2:0] data_bits,
    output logic       parity_error,
    output logic       eoc,
    output logic       coding_error,
    output logic       busy,
    output state_t     dbg_state
);

    localparam int RW = $clog2(2 * HALF_BIT_TICKS + 1);
    localparam logic [RW-1:0] RECOVER_LAST = RW'(2 * HALF_BIT_TICKS - 1);
    localparam logic [3:0]    PARITY_SLOT  = 4'(BITS_PER_GROUP - 1);

    state_t        state, state_n;
    half_t         first_half, first_half_n;
    logic          second_phase, second_phase_n;
    logic [7:0]    grp, grp_n;
    logic [3:0]    grp_cnt, grp_cnt_n;
    logic [RW-1:0] recov_cnt, recov_cnt_n;
    logic          soc_n, data_valid_n, eoc_n, coding_error_n, parity_error_n;
    logic [7:0]    data_n;
    logic [2:0]    data_bits_n;

    logic  start, run, half_done, bit_val;
    half_t half_mod;

    // The first high sample seen in IDLE is tick 0 of the SOC half-bit and
    // fixes bit alignment for the rest of the frame.
    assign start = enable && (state == IDLE) && lm_in;
    assign run   = enable && ((state == SOC1) || (state == SOC2) || (state == DATA));

    subcarrier_half_detector #(
        .HALF_BIT_TICKS(HALF_BIT_TICKS),
        .MOD_THRESHOLD (MOD_THRESHOLD)
    ) u_half_det (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .run      (run),
        .lm_in    (lm_in),
        .half_done(half_done),
        .half_mod (half_mod)
    );

    assign busy      = (state != IDLE);
    assign dbg_state = state;
    assign bit_val   = (first_half == HALF_M);  // (M,U)=1, (U,M)=0

    always_comb begin
        state_n        = state;
        first_half_n   = first_half;
        second_phase_n = second_phase;
        grp_n          = grp;
        grp_cnt_n      = grp_cnt;
        recov_cnt_n    = recov_cnt;
        soc_n          = 1'b0;
        data_valid_n   = 1'b0;
        eoc_n          = 1'b0;
        coding_error_n = 1'b0;
        data_n         = data;
        data_bits_n    = data_bits;
        parity_error_n = parity_error;

        if (!enable) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (lm_in) begin
                        state_n        = SOC1;
                        grp_n          = '0;
                        grp_cnt_n      = '0;
                        second_phase_n = 1'b0;
                    end
                end
                SOC1: begin
                    // An unmodulated first half is a glitch: drop it silently.
                    if (half_done) begin
                        state_n = (half_mod == HALF_M) ? SOC2 : IDLE;
                    end
                end
                SOC2: begin
                    if (half_done) begin
                        if (half_mod == HALF_U) begin
                            state_n        = DATA;
                            soc_n          = 1'b1;
                            second_phase_n = 1'b0;
                        end else begin
                            state_n        = RECOVER;
                            coding_error_n = 1'b1;
                            recov_cnt_n    = '0;
                        end
                    end
                end
                DATA: begin
                    if (half_done) begin
                        if (!second_phase) begin
                            first_half_n   = half_mod;
                            second_phase_n = 1'b1;
                        end else begin
                            second_phase_n = 1'b0;
                            if (first_half != half_mod) begin
                                if (grp_cnt == PARITY_SLOT) begin
                                    data_valid_n   = 1'b1;
                                    data_n         = grp;
                                    data_bits_n    = 3'd0;
                                    parity_error_n = odd_parity_error(grp, bit_val);
                                    grp_n          = '0;
                                    grp_cnt_n      = '0;
                                end else begin
                                    grp_n[grp_cnt[2:0]] = bit_val;
                                    grp_cnt_n           = grp_cnt + 4'd1;
                                end
                            end else if (half_mod == HALF_U) begin
                                // EOC: a short group is a partial byte, a full
                                // 8 bits without parity is a coding error.
                                state_n = IDLE;
                                eoc_n   = 1'b1;
                                if (grp_cnt == PARITY_SLOT) begin
                                    coding_error_n = 1'b1;
                                end else if (grp_cnt != 4'd0) begin
                                    data_valid_n   = 1'b1;
                                    data_n         = grp;
                                    data_bits_n    = grp_cnt[2:0];
                                    parity_error_n = 1'b0;
                                end
                            end else begin
                                state_n        = RECOVER;
                                coding_error_n = 1'b1;
                                recov_cnt_n    = '0;
                            end
                        end
                    end
                end
                RECOVER: begin
                    // Wait for a full bit time of silence before re-arming.
                    if (lm_in) begin
                        recov_cnt_n = '0;
                    end else if (recov_cnt == RECOVER_LAST) begin
                        state_n     = IDLE;
                        recov_cnt_n = '0;
                    end else begin
                        recov_cnt_n = recov_cnt + RW'(1);
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            first_half   <= HALF_U;
            second_phase <= 1'b0;
            grp          <= '0;
            grp_cnt      <= '0;
            recov_cnt    <= '0;
            soc          <= 1'b0;
            data_valid   <= 1'b0;
            eoc          <= 1'b0;
            coding_error <= 1'b0;
            data         <= '0;
            data_bits    <= '0;
            parity_error <= 1'b0;
        end else begin
            state        <= state_n;
            first_half   <= first_half_n;
            second_phase <= second_phase_n;
            grp          <= grp_n;
            grp_cnt      <= grp_cnt_n;
            recov_cnt    <= recov_cnt_n;
            soc          <= soc_n;
            data_valid   <= data_valid_n;
            eoc          <= eoc_n;
            coding_error <= coding_error_n;
            data         <= data_n;
            data_bits    <= data_bits_n;
            parity_error <= parity_error_n;
        end
    end

endmodule

// File: tb/tb_pcd_lm_decoder.sv
// tb_pcd_lm_decoder: directed bench for pcd_lm_decoder. The driver generates
// PICC load modulation (fc/16 subcarrier gated by Manchester halves); every
// expected output event is queued when its stimulus is driven and popped by
// a monitor when the DUT strobes.
module tb_pcd_lm_decoder;
    import pcd_pkg::*;

    localparam int HALF = 64;

    // event kinds
    localparam logic [2:0] K_SOC    = 3'd1;
    localparam logic [2:0] K_DV     = 3'd2;
    localparam logic [2:0] K_EOC    = 3'd3;
    localparam logic [2:0] K_CERR   = 3'd4;
    localparam logic [2:0] K_DV_EOC = 3'd5;
    localparam logic [2:0] K_CE_EOC = 3'd6;
    localparam logic [2:0] K_OTHER  = 3'd7;

    logic       clk = 1'b0;
    logic       rst, lm_in, enable;
    logic       soc, data_valid, parity_error, eoc, coding_error, busy;
    logic [7:0] data;
    logic [2:0] data_bits;
    state_t     dbg_state;

    pcd_lm_decoder #(.HALF_BIT_TICKS(HALF), .MOD_THRESHOLD(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .lm_in       (lm_in),
        .enable      (enable),
        .soc         (soc),
        .data_valid  (data_valid),
        .data        (data),
        .data_bits   (data_bits),
        .parity_error(parity_error),
        .eoc         (eoc),
        .coding_error(coding_error),
        .busy        (busy),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    logic [14:0] exp_q[$];
    int n_assert = 0;
    int n_fail   = 0;
    int soc_cyc = 0, dv_cyc = 0, eoc_cyc = 0;

    function automatic logic [14:0] ev(input logic [2:0] kind, input logic [7:0] d,
                                       input logic [2:0] bits, input logic perr);
        return {kind, d, bits, perr};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [3:0]  mon_p;
    logic [2:0]  mon_kind;
    logic [14:0] mon_obs;
    logic [14:0] mon_exp;

    always @(negedge clk) begin
        if (!rst && (soc || data_valid || eoc || coding_error)) begin
            mon_p = {soc, data_valid, eoc, coding_error};
            case (mon_p)
                4'b1000: mon_kind = K_SOC;
                4'b0100: mon_kind = K_DV;
                4'b0010: mon_kind = K_EOC;
                4'b0001: mon_kind = K_CERR;
                4'b0110: mon_kind = K_DV_EOC;
                4'b0011: mon_kind = K_CE_EOC;
                default: mon_kind = K_OTHER;
            endcase
            if (data_valid) mon_obs = ev(mon_kind, data, data_bits, parity_error);
            else            mon_obs = ev(mon_kind, 8'h00, 3'd0, 1'b0);
            if (soc)        soc_cyc = cyc;
            if (data_valid) dv_cyc  = cyc;
            if (eoc)        eoc_cyc = cyc;
            if (exp_q.size() == 0) begin
                check("unexpected_event", 32'(mon_obs), 32'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("event", 32'(mon_obs), 32'(mon_exp));
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Inputs change on the falling edge; the DUT samples on the rising edge.
    task automatic half(input logic m);
        for (int k = 0; k < HALF; k++) begin
            lm_in = m && ((k % 16) < 8);
            @(negedge clk);
        end
    endtask

    task automatic send_bit(input logic b);
        if (b) begin half(1'b1); half(1'b0); end
        else   begin half(1'b0); half(1'b1); end
    endtask

    task automatic send_soc();
        half(1'b1);
        half(1'b0);
    endtask

    task automatic send_eoc();
        half(1'b0);
        half(1'b0);
    endtask

    task automatic send_data(input logic [7:0] d, input int n);
        for (int i = 0; i < n; i++) send_bit(d[i]);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic p);
        send_data(d, 8);
        send_bit(p);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            lm_in = 1'b0;
            @(negedge clk);
        end
    endtask

    // Full clean frame of one byte with correct odd parity.
    task automatic clean_frame(input logic [7:0] d);
        exp_q.push_back(ev(K_SOC, 8'h00, 3'd0, 1'b0));
        exp_q.push_back(ev(K_DV, d, 3'd0, 1'b0));
        exp_q.push_back(ev(K_EOC, 8'h00, 3'd0, 1'b0));
        send_soc();
        send_byte(d, ~(^d));
        send_eoc();
        idle(20);
    endtask

    // ---------------- directed sequence ----------------
    int start_cyc;

    initial begin
        rst    = 1'b1;
        enable = 1'b1;
        lm_in  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              32'({soc, data_valid, eoc, coding_error, data, data_bits, parity_error, busy}), 32'd0);
        check("reset_state", 32'(dbg_state), 32'(IDLE));
        rst = 1'b0;
        idle(10);

        // nominal byte 0xA5, plus latency checks
        start_cyc = cyc + 1;
        clean_frame(8'hA5);
        check("soc_latency", 32'(soc_cyc - start_cyc), 32'd128);
        check("dv_latency", 32'(dv_cyc - soc_cyc), 32'd1152);
        check("eoc_latency", 32'(eoc_cyc - dv_cyc), 32'd128);

        // 4-bit ACK: partial byte with same-cycle eoc
        exp_q.push_back(ev(K_SOC, 8'h00, 3'd0, 1'b0));
        exp_q.push_back(ev(K_DV_EOC, 8'h0A, 3'd4, 1'b0));
        send_soc();
        send_data(8'h0A, 4);
        send_eoc();
        idle(20);

        // bad parity on 0x00, then a good byte and eoc
        exp_q.push_back(ev(K_SOC, 8'h00, 3'd0, 1'b0));
        exp_q.push_back(ev(K_DV, 8'h00, 3'd0, 1'b1));
        exp_q.push_back(ev(K_DV, 8'h5A, 3'd0, 1'b0));
        exp_q.push_back(ev(K_EOC, 8'h00, 3'd0, 1'b0));
        send_soc();
        send_byte(8'h00, 1'b0);
        send_byte(8'h5A, ~(^8'h5A));
        send_eoc();
        idle(20);

        // (M,M) in bit 3, recovery after 128 silent cycles
        exp_q.push_back(ev(K_SOC, 8'h00, 3'd0, 1'b0));
        exp_q.push_back(ev(K_CERR, 8'h00, 3'd0, 1'b0));
        send_soc();
        send_data(8'h05, 3);
        half(1'b1);
        half(1'b1);
        idle(128);
        check("recover_busy", 32'(busy), 32'd1);
        idle(1);
        check("recover_idle", 32'(busy), 32'd0);
        idle(10);
        clean_frame(8'h3C);

        // single-cycle glitch in IDLE
        lm_in = 1'b1;
        @(negedge clk);
        idle(63);
        check("glitch_busy", 32'(busy), 32'd1);
        idle(1);
        check("glitch_idle", 32'(busy), 32'd0);
        idle(10);

        // 8 data bits with no parity before EOC
        exp_q.push_back(ev(K_SOC, 8'h00, 3'd0, 1'b0));
        exp_q.push_back(ev(K_CE_EOC, 8'h00, 3'd0, 1'b0));
        send_soc();
        send_data(8'h81, 8);
        send_eoc();
        idle(20);

        // reset mid-byte
        exp_q.push_back(ev(K_SOC, 8'h00, 3'd0, 1'b0));
        send_soc();
        send_data(8'hFF, 4);
        lm_in = 1'b0;
        rst   = 1'b1;
        #1;
        check("midrst_outputs",
              32'({soc, data_valid, eoc, coding_error, data, data_bits, parity_error, busy}), 32'd0);
        check("midrst_state", 32'(dbg_state), 32'(IDLE));
        @(negedge clk);
        rst = 1'b0;
        idle(20);
        clean_frame(8'hC3);

        // enable dropped mid-byte
        exp_q.push_back(ev(K_SOC, 8'h00, 3'd0, 1'b0));
        send_soc();
        send_data(8'h0F, 3);
        enable = 1'b0;
        lm_in  = 1'b0;
        @(negedge clk);
        check("disable_busy", 32'(busy), 32'd0);
        check("disable_state", 32'(dbg_state), 32'(IDLE));
        enable = 1'b1;
        idle(200);
        clean_frame(8'h96);

        idle(20);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
